// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg
// Shared definitions for the CPU pipeline stage registers.
//   - Control-bundle field widths and bit offsets.
//   - Bubble (no-op) control constants for each stage.
//   - Pack/unpack helpers between the field struct and the flat bundle.
// There are no ports. Modules use this package through import cpu_pipe_pkg::*.
package cpu_pipe_pkg;

    // Control field widths
    localparam int PC_SEL_W    = 2;
    localparam int REG_WRITE_W = 2;
    localparam int MEM_WRITE_W = 1;
    localparam int BRANCH_W    = 1;
    localparam int ALU_CTRL_W  = 4;
    localparam int OP_B_SEL_W  = 1;
    localparam int REG_WE_W    = 1;

    // Bit offsets within the flat control bundle (LSB first)
    localparam int PC_SEL_LSB    = 0;
    localparam int REG_WRITE_LSB = PC_SEL_LSB    + PC_SEL_W;
    localparam int MEM_WRITE_LSB = REG_WRITE_LSB + REG_WRITE_W;
    localparam int BRANCH_LSB    = MEM_WRITE_LSB + MEM_WRITE_W;
    localparam int ALU_CTRL_LSB  = BRANCH_LSB    + BRANCH_W;
    localparam int OP_B_SEL_LSB  = ALU_CTRL_LSB  + ALU_CTRL_W;
    localparam int REG_WE_LSB    = OP_B_SEL_LSB  + OP_B_SEL_W;
    localparam int CTRL_FIELDS_W = REG_WE_LSB    + REG_WE_W;

    // The flat bundle is wider than the fields. The spare upper bits leave room to grow.
    localparam int STAGE_CTRL_W = 16;

    // Declare members MSB first so that each bit position matches the *_LSB offsets above.
    typedef struct packed {
        logic [REG_WE_W-1:0]    reg_we;
        logic [OP_B_SEL_W-1:0]  op_b_sel;
        logic [ALU_CTRL_W-1:0]  alu_ctrl;
        logic [BRANCH_W-1:0]    branch;
        logic [MEM_WRITE_W-1:0] mem_write;
        logic [REG_WRITE_W-1:0] reg_write;
        logic [PC_SEL_W-1:0]    pc_sel;
    } ctrl_fields_t;

    // Bubble control per stage. All enables are off, so a bubble never writes state.
    localparam logic [STAGE_CTRL_W-1:0] IF_ID_CTRL_BUBBLE  = '0;
    localparam logic [STAGE_CTRL_W-1:0] ID_EX_CTRL_BUBBLE  = '0;
    localparam logic [STAGE_CTRL_W-1:0] EX_MEM_CTRL_BUBBLE = '0;
    localparam logic [STAGE_CTRL_W-1:0] MEM_WB_CTRL_BUBBLE = '0;

    function automatic logic [STAGE_CTRL_W-1:0] pack_ctrl(input ctrl_fields_t f);
        return {{(STAGE_CTRL_W-CTRL_FIELDS_W){1'b0}}, f};
    endfunction

    function automatic ctrl_fields_t unpack_ctrl(input logic [STAGE_CTRL_W-1:0] v);
        return ctrl_fields_t'(v[CTRL_FIELDS_W-1:0]);
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter
// A saturating up-counter used for pipeline profiling.
// Ports:
//   clk, rst_n - clock, and reset (asynchronous, active-low)
//   inc        - add one this cycle; the count stops at all-ones
//   clr        - synchronous clear; takes priority over inc
//   count      - current count value
module pipe_sat_counter
    import cpu_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// A generic pipeline stage register. It carries a control bundle and a data bundle
// under a valid/ready handshake.
// Ports:
//   clk, rst_n          - clock, and reset (asynchronous, active-low)
//   flush_i             - kill every held entry and the incoming entry (highest priority)
//   stall_i             - freeze the stage: no transfer in and no transfer out
//   cnt_clr_i           - synchronous clear of both performance counters
//   in_valid_i/in_ready_o, in_ctrl_i, in_data_i     - upstream side
//   out_valid_o/out_ready_i, out_ctrl_o, out_data_o - downstream side
//   bubble_cnt_o        - saturating count of cycles with out_valid_o=0
//   stall_cnt_o         - saturating count of cycles where the head is valid but not taken
//
// Handshake: an entry moves across an interface on a rising edge only when valid and
// ready are both high in the cycle before that edge. Valid does not depend on ready.
// A transfer out also requires stall_i=0.
// Once valid is raised, the sender holds the entry until it is taken. A flush is the
// only exception.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int                CTRL_W      = 16,
    parameter int                DATA_W      = 160,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
    parameter bit                SKID        = 1'b0,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              cnt_clr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;
    logic              xfer_in;
    logic              xfer_out;

    assign xfer_in  = in_valid_i & in_ready_o;
    assign xfer_out = valid_q & out_ready_i & ~stall_i;

    generate
        if (SKID == 1'b0) begin : g_single
            // The ready path is combinational through out_ready_i.
            assign in_ready_o = ~stall_i & (~valid_q | out_ready_i);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    ctrl_q  <= CTRL_BUBBLE;
                    data_q  <= '0;
                end else if (flush_i) begin
                    valid_q <= 1'b0;
                    ctrl_q  <= CTRL_BUBBLE;
                end else if (xfer_in) begin
                    valid_q <= 1'b1;
                    ctrl_q  <= in_ctrl_i;
                    data_q  <= in_data_i;
                end else if (xfer_out) begin
                    valid_q <= 1'b0;
                    ctrl_q  <= CTRL_BUBBLE;
                end
            end
        end else begin : g_skid
            logic              skid_valid;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;

            // Ready depends only on registered state, plus stall_i.
            // The skid entry catches the one entry accepted while main could not drain.
            assign in_ready_o = ~skid_valid & ~stall_i;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q    <= 1'b0;
                    ctrl_q     <= CTRL_BUBBLE;
                    data_q     <= '0;
                    skid_valid <= 1'b0;
                    skid_ctrl  <= CTRL_BUBBLE;
                    skid_data  <= '0;
                end else if (flush_i) begin
                    valid_q    <= 1'b0;
                    ctrl_q     <= CTRL_BUBBLE;
                    skid_valid <= 1'b0;
                    skid_ctrl  <= CTRL_BUBBLE;
                end else if (xfer_out) begin
                    if (skid_valid) begin
                        // in_ready_o is low while skid is full, so no entry can arrive
                        // in this same cycle.
                        ctrl_q     <= skid_ctrl;
                        data_q     <= skid_data;
                        skid_valid <= 1'b0;
                        skid_ctrl  <= CTRL_BUBBLE;
                    end else if (xfer_in) begin
                        ctrl_q <= in_ctrl_i;
                        data_q <= in_data_i;
                    end else begin
                        valid_q <= 1'b0;
                        ctrl_q  <= CTRL_BUBBLE;
                    end
                end else if (xfer_in) begin
                    if (valid_q) begin
                        skid_valid <= 1'b1;
                        skid_ctrl  <= in_ctrl_i;
                        skid_data  <= in_data_i;
                    end else begin
                        valid_q <= 1'b1;
                        ctrl_q  <= in_ctrl_i;
                        data_q  <= in_data_i;
                    end
                end
            end
        end
    endgenerate

    assign out_valid_o = valid_q;
    // Mask the control bundle so downstream never sees stale write enables.
    assign out_ctrl_o  = valid_q ? ctrl_q : CTRL_BUBBLE;
    assign out_data_o  = data_q;

    pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~valid_q),
        .clr   (cnt_clr_i),
        .count (bubble_cnt_o)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (valid_q & ~xfer_out),
        .clr   (cnt_clr_i),
        .count (stall_cnt_o)
    );

endmodule
